// File: rtl/mem_phase_scheduler.sv
// Time-slotted arbiter sharing one single-port memory between
// instruction fetch and load/store, with read-return tagging.
module mem_phase_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_grant,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_grant,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        phase,
    output logic        if_stall,
    output logic        ls_stall,
    output logic [15:0] wait_cnt
);

    typedef enum logic {
        PH_IF = 1'b0,
        PH_LS = 1'b1
    } phase_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_LS   = 2'd2
    } tag_t;

    phase_t      r_phase;
    phase_t      w_phase_nxt;
    tag_t        r_tag;
    tag_t        w_tag_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_nxt;
    logic        w_active;
    logic        w_if_grant;
    logic        w_ls_grant;
    logic        w_if_stall;
    logic        w_ls_stall;

    // Slot owner register: toggles every enabled cycle, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_IF;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Next slot owner: alternate while enabled, freeze otherwise
    always_comb begin
        w_phase_nxt = r_phase;
        if (en) begin
            if (r_phase == PH_IF) begin
                w_phase_nxt = PH_LS;
            end else begin
                w_phase_nxt = PH_IF;
            end
        end
    end

    // Grants: owner wins; the idle owner lends its slot to the other side
    always_comb begin
        w_active   = en & ~rst;
        w_if_grant = w_active & if_req
                   & ((r_phase == PH_IF) | ~ls_req);
        w_ls_grant = w_active & ls_req
                   & ((r_phase == PH_LS) | ~if_req);
        w_if_stall = if_req & ~w_if_grant;
        w_ls_stall = ls_req & ~w_ls_grant;
    end

    // Memory port mirrors whichever requester holds the grant
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (w_if_grant) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end else if (w_ls_grant) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
    end

    // Classify this cycle's access so its read data can be routed next cycle
    always_comb begin
        w_tag_nxt = TAG_NONE;
        if (w_if_grant) begin
            w_tag_nxt = TAG_IF;
        end else if (w_ls_grant && !ls_we) begin
            w_tag_nxt = TAG_LS;
        end
    end

    // Return tag register; reset drops any in-flight read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= TAG_NONE;
        end else begin
            r_tag <= w_tag_nxt;
        end
    end

    // Saturating stall counter increment
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if ((w_if_stall || w_ls_stall) && (r_wait_cnt != 16'hFFFF)) begin
            w_wait_nxt = r_wait_cnt + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 16'h0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Route returning read data to its requester, zero otherwise
    always_comb begin
        if_rvalid = (r_tag == TAG_IF);
        ls_rvalid = (r_tag == TAG_LS);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        ls_rdata  = ls_rvalid ? mem_rdata : 32'h0;
    end

    // Status and grant outputs
    always_comb begin
        if_grant = w_if_grant;
        ls_grant = w_ls_grant;
        if_stall = w_if_stall;
        ls_stall = w_ls_stall;
        phase    = r_phase;
        wait_cnt = r_wait_cnt;
    end

endmodule

// File: tb/tb_mem_phase_scheduler.sv
// Directed bench for mem_phase_scheduler with a reference model and
// a queue of expected read returns.
module tb_mem_phase_scheduler;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_grant, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_grant, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        phase, if_stall, ls_stall;
    logic [15:0] wait_cnt;

    int          checks = 0;
    int          errors = 0;

    logic        m_phase;
    logic [15:0] m_cnt;
    logic [33:0] ret_q[$];

    mem_phase_scheduler dut (
        .clk(clk), .rst(rst), .en(en),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_grant(ls_grant),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .phase(phase), .if_stall(if_stall), .ls_stall(ls_stall),
        .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mfun(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory with one-cycle read latency; output always changes
    always @(posedge clk) mem_rdata <= mfun(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag, input bit check);
        logic        eg_if, eg_ls, e_ifs, e_lss;
        logic        e_men, e_mwe;
        logic [3:0]  e_mbe;
        logic [31:0] e_ma, e_mwd;
        logic [33:0] front, nxt;
        @(negedge clk);
        eg_if = en & ~rst & if_req & (~m_phase | ~ls_req);
        eg_ls = en & ~rst & ls_req & (m_phase | ~if_req);
        e_ifs = if_req & ~eg_if;
        e_lss = ls_req & ~eg_ls;
        e_men = eg_if | eg_ls;
        e_mwe = eg_ls & ls_we;
        e_mbe = eg_if ? 4'hF : (eg_ls ? ls_be : 4'h0);
        e_ma  = eg_if ? if_addr : (eg_ls ? ls_addr : 32'h0);
        e_mwd = eg_ls ? ls_wdata : 32'h0;
        front = (ret_q.size() > 0) ? ret_q.pop_front() : 34'h0;
        if (check) begin
            chk($sformatf("%s.if_grant", tag), 32'(if_grant), 32'(eg_if));
            chk($sformatf("%s.ls_grant", tag), 32'(ls_grant), 32'(eg_ls));
            chk($sformatf("%s.if_stall", tag), 32'(if_stall), 32'(e_ifs));
            chk($sformatf("%s.ls_stall", tag), 32'(ls_stall), 32'(e_lss));
            chk($sformatf("%s.mem_en", tag), 32'(mem_en), 32'(e_men));
            chk($sformatf("%s.mem_we", tag), 32'(mem_we), 32'(e_mwe));
            chk($sformatf("%s.mem_be", tag), 32'(mem_be), 32'(e_mbe));
            chk($sformatf("%s.mem_addr", tag), mem_addr, e_ma);
            chk($sformatf("%s.mem_wdata", tag), mem_wdata, e_mwd);
            chk($sformatf("%s.phase", tag), 32'(phase), 32'(m_phase));
            chk($sformatf("%s.wait_cnt", tag), 32'(wait_cnt), 32'(m_cnt));
            chk($sformatf("%s.if_rvalid", tag), 32'(if_rvalid),
                32'(front[33]));
            chk($sformatf("%s.ls_rvalid", tag), 32'(ls_rvalid),
                32'(front[32]));
            chk($sformatf("%s.if_rdata", tag), if_rdata,
                front[33] ? front[31:0] : 32'h0);
            chk($sformatf("%s.ls_rdata", tag), ls_rdata,
                front[32] ? front[31:0] : 32'h0);
        end
        nxt = 34'h0;
        if (!rst && eg_if) nxt = {2'b10, mfun(if_addr)};
        else if (!rst && eg_ls && !ls_we) nxt = {2'b01, mfun(ls_addr)};
        ret_q.push_back(nxt);
        if (rst) begin
            m_cnt   = 16'h0;
            m_phase = 1'b0;
        end else begin
            if ((e_ifs | e_lss) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (en) m_phase = ~m_phase;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0;
        ls_addr = 32'h0; ls_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        m_phase = 1'b0;
        m_cnt   = 16'h0;
        ret_q.push_back(34'h0);
        rst = 1'b0;
        tick("reset_idle", 1'b1);

        // Alternation with both requesters held
        while (m_phase != 1'b0) tick("align0", 1'b1);
        if_req = 1'b1; if_addr = 32'h0000_1000;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF;
        ls_addr = 32'h0000_0100; ls_wdata = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            tick($sformatf("alt%0d", i), 1'b1);
            if_addr = if_addr + 32'h4;
        end

        // Borrow: store while fetch is idle in a fetch slot
        if_req = 1'b0; ls_req = 1'b0;
        while (m_phase != 1'b0) tick("align1", 1'b1);
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h3;
        ls_addr = 32'h0000_0040; ls_wdata = 32'hDEAD_BEEF;
        tick("borrow", 1'b1);
        ls_req = 1'b0; ls_we = 1'b0;
        tick("borrow_norv", 1'b1);

        // Conflict in a load/store slot, then fetch gets its slot
        while (m_phase != 1'b1) tick("align2", 1'b1);
        if_req = 1'b1; if_addr = 32'h0000_2000;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF;
        ls_addr = 32'h0000_0080;
        tick("conflict", 1'b1);
        ls_req = 1'b0;
        tick("conflict_if", 1'b1);

        // Enable low: return from previous grant completes, then frozen
        ls_req = 1'b1; en = 1'b0;
        for (int i = 0; i < 5; i++) tick($sformatf("en_low%0d", i), 1'b1);
        en = 1'b1;
        tick("en_back", 1'b1);
        tick("en_back2", 1'b1);

        // Reset arriving with a load requested
        if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0;
        ls_addr = 32'h0000_0300;
        while (m_phase != 1'b1) tick("align3", 1'b1);
        tick("pre_rst", 1'b1);
        rst = 1'b1;
        tick("rst_mid", 1'b1);
        rst = 1'b0; ls_req = 1'b0;
        tick("post_rst", 1'b1);

        // Saturation: long stall run, then watch the counter clamp
        en = 1'b0; if_req = 1'b1;
        while (m_cnt != 16'hFFFE) tick("fill", 1'b0);
        tick("sat0", 1'b1);
        tick("sat1", 1'b1);
        tick("sat2", 1'b1);
        tick("sat3", 1'b1);
        chk("sat_model", 32'(wait_cnt), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
